rca_n_bit: RTL and testbench
============================

Name: rca_n_bit

Overview:
- Parameterised N-bit ripple-carry adder with registered outputs.
- Built as a chain of N one-bit full-adder cells; carry ripples from bit 0 to bit N-1.
- Used as a datapath adder where operands are two's-complement signed values.
- One clock, one output register stage; the sum and carry are valid one cycle after the operands are sampled.

Parameters:
- N, 6, operand and sum width in bits; legal range N >= 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  N  operand A; signed two's complement.
- B  input  N  operand B; signed two's complement.
- cin  input  1  carry into bit 0.
- sum  output  N  registered A+B+cin, low N bits; signed.
- cout  output  1  registered carry out of bit N-1.

Behaviour:
- Combinational core:
  - For each bit i: s[i] = A[i] ^ B[i] ^ c[i].
  - c[i+1] = (A[i]&B[i]) | (A[i]&c[i]) | (B[i]&c[i]).
  - c[0] = cin.
  - Implemented as an explicit generate chain of full-adder cells. No behavioural "+" operator.
- Register stage:
  - On each rising clk edge with rst=0: sum <= s[N-1:0] and cout <= c[N].
  - Latency is exactly 1 cycle. A new result is produced every cycle; there is no handshake and no stall.
- Reset:
  - When rst=1 at a rising edge, sum <= 0 and cout <= 0.
  - Reset takes priority over operand capture.
  - Operands present during reset are discarded. The first valid result appears one cycle after rst is deasserted, using the operands sampled at that edge.
- Width and arithmetic rules:
  - Result wraps modulo 2^N.
  - cout is the unsigned carry. For signed operands it is not an overflow indicator.
  - With sign-extended inputs, the signed sum fits when it lies in [-2^(N-1), 2^(N-1)-1].
- Boundary cases:
  - A=all-ones, B=0, cin=1 -> sum=0, cout=1 (full carry ripple through all N bits).
  - A=B=0, cin=0 -> sum=0, cout=0.
  - Negative plus negative sets cout=1 whenever the low N bits wrap.
- Inputs are sampled only at the clock edge; glitches on the combinational chain between edges are not visible at the outputs.

Optional Feature:
- Macro: RCA_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside sum.
  - ovf = c[N] ^ c[N-1] (signed overflow).
  - Reset value of ovf is 0.
- Not defined:
  - Port ovf does not exist.
  - No extra logic is generated.
- sum and cout behaviour is identical in both builds.

Test Plan (N=6, values in decimal signed):
- Reset check:
  - Drive rst=1 for 2 cycles with A=5, B=3.
  - Required: sum=0, cout=0 during reset.
  - After release: sum=8, cout=0 one cycle later.
- Exhaustive signed sweep, cin=0:
  - A and B each from -8 to 7, one pair per cycle.
  - Required: sum equals A+B as a 6-bit signed value one cycle later.
  - Examples: -8+-8 -> sum=-16, cout=1. 7+7 -> sum=14, cout=0. -1+1 -> sum=0, cout=1.
  - With RCA_OVF_EN: ovf=0 for the entire sweep.
- Carry ripple with cin=1:
  - A=31, B=0 -> sum=-32 (100000b), cout=0; ovf=1 if enabled.
  - A=-1, B=0 -> sum=0, cout=1, ovf=0.
- Back-to-back throughput:
  - Change operands every cycle: (1,2), (3,4), (-5,-6).
  - Required: sum 3, 7, -11 on consecutive cycles, each one cycle after its input.
- Signed overflow, RCA_OVF_EN defined:
  - A=20, B=20 -> sum=-24, cout=0, ovf=1.
  - A=-20, B=-20 -> sum=24, cout=1, ovf=1.

Source files
------------

// File: rtl/rca_n_bit.sv
// rtl/rca_n_bit.sv - N-bit ripple-carry adder with a registered result; RCA_OVF_EN adds a registered signed-overflow flag
module rca_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module rca_n_bit #(
    parameter int N = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N-1:0] A,
    input  logic signed [N-1:0] B,
    input  logic                cin,
    output logic signed [N-1:0] sum,
    output logic                cout
`ifdef RCA_OVF_EN
    ,
    output logic                ovf
`endif
);
    logic [N:0]   c;
    logic [N-1:0] s;

    assign c[0] = cin;

    // One full-adder cell per bit; carry ripples from bit 0 upward.
    for (genvar i = 0; i < N; i++) begin : g_cell
        rca_fa_cell u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= s;
            cout <= c[N];
        end
    end

`ifdef RCA_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= c[N] ^ c[N-1];
        end
    end
`endif

endmodule

// File: tb/tb_rca_n_bit.sv
// tb/tb_rca_n_bit.sv - randomized and directed self-checking bench for rca_n_bit
module tb_rca_n_bit;
    localparam int N = 6;
    localparam int MOD = 1 << N;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [N-1:0] A;
    logic signed [N-1:0] B;
    logic                cin;
    logic signed [N-1:0] sum;
    logic                cout;
`ifdef RCA_OVF_EN
    logic                ovf;
`endif

    int checks = 0;
    int errors = 0;

    int exp_sum;
    bit exp_cout;
    bit exp_ovf;
    bit model_valid = 1'b0;

    always #5 clk = ~clk;

    rca_n_bit #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
`ifdef RCA_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    function automatic int unsigned_total(input logic signed [N-1:0] a, input logic signed [N-1:0] b, input logic ci);
        int ua, ub;
        ua = int'($unsigned(a));
        ub = int'($unsigned(b));
        return ua + ub + int'(ci);
    endfunction

    function automatic bit signed_overflow(input logic signed [N-1:0] a, input logic signed [N-1:0] b, input logic ci);
        int sv;
        sv = int'(a) + int'(b) + int'(ci);
        return (sv < -(MOD / 2)) || (sv > (MOD / 2 - 1));
    endfunction

    // Reference model: integer arithmetic on the sampled operands.
    always @(posedge clk) begin
        if (rst) begin
            exp_sum  <= 0;
            exp_cout <= 1'b0;
            exp_ovf  <= 1'b0;
        end else begin
            exp_sum  <= unsigned_total(A, B, cin) % MOD;
            exp_cout <= unsigned_total(A, B, cin) >= MOD;
            exp_ovf  <= signed_overflow(A, B, cin);
        end
        model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (int'($unsigned(sum)) != exp_sum || cout !== exp_cout) begin
                errors++;
                $display("FAIL model: sum=%0d cout=%b required sum=%0d cout=%b (A=%0d B=%0d cin=%b)",
                         $unsigned(sum), cout, exp_sum, exp_cout, A, B, cin);
            end
`ifdef RCA_OVF_EN
            checks++;
            if (ovf !== exp_ovf) begin
                errors++;
                $display("FAIL model_ovf: ovf=%b required %b", ovf, exp_ovf);
            end
`endif
        end
    end

    task automatic apply(input int a, input int b, input logic ci);
        A   = a[N-1:0];
        B   = b[N-1:0];
        cin = ci;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string name, input int want_sum, input logic want_cout);
        checks++;
        if (int'(sum) != want_sum || cout !== want_cout) begin
            errors++;
            $display("FAIL %s: sum=%0d cout=%b required sum=%0d cout=%b", name, int'(sum), cout, want_sum, want_cout);
        end
    endtask

`ifdef RCA_OVF_EN
    task automatic lit_ovf(input string name, input logic want);
        checks++;
        if (ovf !== want) begin
            errors++;
            $display("FAIL %s_ovf: ovf=%b required %b", name, ovf, want);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        A   = 6'sd5;
        B   = 6'sd3;
        cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lit("reset_cycle1", 0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        lit("reset_cycle2", 0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lit("after_reset", 8, 1'b0);

        for (int a = -8; a <= 7; a++) begin
            for (int b = -8; b <= 7; b++) begin
                apply(a, b, 1'b0);
            end
        end
        apply(-8, -8, 1'b0); lit("neg8_plus_neg8", -16, 1'b1);
        apply(7, 7, 1'b0);   lit("seven_plus_seven", 14, 1'b0);
        apply(-1, 1, 1'b0);  lit("neg1_plus_1", 0, 1'b1);
        apply(0, 0, 1'b0);   lit("zero_zero", 0, 1'b0);

        apply(31, 0, 1'b1);  lit("ripple_31_cin", -32, 1'b0);
`ifdef RCA_OVF_EN
        lit_ovf("ripple_31_cin", 1'b1);
`endif
        apply(-1, 0, 1'b1);  lit("ripple_all_ones", 0, 1'b1);
`ifdef RCA_OVF_EN
        lit_ovf("ripple_all_ones", 1'b0);
`endif

        apply(1, 2, 1'b0);   lit("b2b_1", 3, 1'b0);
        apply(3, 4, 1'b0);   lit("b2b_2", 7, 1'b0);
        apply(-5, -6, 1'b0); lit("b2b_3", -11, 1'b1);

        apply(20, 20, 1'b0);   lit("ovf_pos", -24, 1'b0);
`ifdef RCA_OVF_EN
        lit_ovf("ovf_pos", 1'b1);
`endif
        apply(-20, -20, 1'b0); lit("ovf_neg", 24, 1'b1);
`ifdef RCA_OVF_EN
        lit_ovf("ovf_neg", 1'b1);
`endif

        // Random operands with occasional reset pulses to exercise reset priority.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            apply(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)), 1'($urandom_range(0, 1)));
        end
        rst = 1'b1;
        apply(17, 9, 1'b1);
        lit("reset_priority", 0, 1'b0);
        rst = 1'b0;
        apply(-32, -32, 1'b0);
        lit("min_plus_min", 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
